// File: rtl/fsm_input_conditioner.sv
// Input conditioner: per-channel pad synchroniser, stable-count debouncer and rise/fall pulse generator.
// Optional saturating glitch counter is built only when FSM_IN_GLITCH_CNT_EN is defined.
module fsm_input_conditioner #(
  parameter int unsigned N_CH            = 3,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [7:0]      glitch_cnt
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES <= 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0]  r_sync [SYNC_STAGES];
  logic [N_CH-1:0]  r_stable;
  logic [N_CH-1:0]  r_rise;
  logic [N_CH-1:0]  r_fall;
  logic [CNT_W-1:0] r_cnt  [N_CH];

  logic [N_CH-1:0]  w_s;
  logic [N_CH-1:0]  w_stable_nxt;
  logic [N_CH-1:0]  w_rise_nxt;
  logic [N_CH-1:0]  w_fall_nxt;
  logic [CNT_W-1:0] w_cnt_nxt [N_CH];

  // Resynchronise the asynchronous pad inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= raw_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Debounce decision: any return to the stable value restarts the count
  always_comb begin
    w_stable_nxt = r_stable;
    w_rise_nxt   = '0;
    w_fall_nxt   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_cnt_nxt[i] = '0;
      if (w_s[i] != r_stable[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_stable_nxt[i] = w_s[i];
          w_rise_nxt[i]   = w_s[i];
          w_fall_nxt[i]   = ~w_s[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_stable <= w_stable_nxt;
      r_rise   <= w_rise_nxt;
      r_fall   <= w_fall_nxt;
      for (int unsigned i = 0; i < N_CH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign level_out  = r_stable;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

`ifdef FSM_IN_GLITCH_CNT_EN
  logic       w_glitch_any;
  logic [7:0] r_glitch_cnt;

  // A bounce is a return to the stable value while a count was in progress
  always_comb begin
    w_glitch_any = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if ((w_s[i] == r_stable[i]) && (r_cnt[i] != '0)) begin
        w_glitch_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_glitch_cnt <= 8'h00;
    end else if (w_glitch_any && (r_glitch_cnt != 8'hFF)) begin
      r_glitch_cnt <= r_glitch_cnt + 8'd1;
    end
  end

  assign glitch_cnt = r_glitch_cnt;
`else
  assign glitch_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Scoreboard bench for fsm_input_conditioner (N_CH=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Expected glitch counts follow FSM_IN_GLITCH_CNT_EN.
module tb_fsm_input_conditioner;

  localparam int unsigned N_CH = 3;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
  localparam int          LAT  = SYNC + DEB;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N_CH-1:0] raw_in = '0;
  logic [N_CH-1:0] level_out;
  logic [N_CH-1:0] rise_pulse;
  logic [N_CH-1:0] fall_pulse;
  logic [7:0]      glitch_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] level;
    int              at;
  } ev_t;

  ev_t exp_q[$];

  fsm_input_conditioner #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .level_out(level_out), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at the negedge where raw_in changes; pulse due LAT edges later
  task automatic push(input logic [N_CH-1:0] r, input logic [N_CH-1:0] f, input logic [N_CH-1:0] l);
    ev_t e;
    e.rise = r; e.fall = f; e.level = l; e.at = cyc + LAT;
    exp_q.push_back(e);
  endtask

  function automatic logic [7:0] gl_exp(input int n);
`ifdef FSM_IN_GLITCH_CNT_EN
    return (n > 255) ? 8'hFF : 8'(n);
`else
    return (n > 255) ? 8'h00 : 8'h00;
`endif
  endfunction

  // Monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin : monitor
    ev_t ev;
    if ((rise_pulse | fall_pulse) != '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'({rise_pulse, fall_pulse}), 32'd0);
      end else begin
        ev = exp_q.pop_front();
        chk("rise_pulse", 32'(rise_pulse), 32'(ev.rise));
        chk("fall_pulse", 32'(fall_pulse), 32'(ev.fall));
        chk("level_at_pulse", 32'(level_out), 32'(ev.level));
        chk("pulse_cycle", 32'(cyc), 32'(ev.at));
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].at) begin
      ev = exp_q.pop_front();
      chk("missed_pulse", 32'(cyc), 32'(ev.at));
    end
  end

  initial begin
    int ng;
    reset  = 1'b1;
    raw_in = 3'b000;
    repeat (2) @(negedge clk);
    chk("reset_level", 32'(level_out), 32'd0);
    chk("reset_rise", 32'(rise_pulse), 32'd0);
    chk("reset_fall", 32'(fall_pulse), 32'd0);
    chk("reset_glitch", 32'(glitch_cnt), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_level", 32'(level_out), 32'd0);
      chk("idle_glitch", 32'(glitch_cnt), 32'd0);
    end

    // Single rise on channel 0
    raw_in = 3'b001;
    push(3'b001, 3'b000, 3'b001);
    repeat (LAT - 1) @(negedge clk);
    chk("rise_not_early", 32'(level_out), 32'd0);
    @(negedge clk);
    chk("rise_level", 32'(level_out), 32'b001);
    @(negedge clk);
    chk("rise_one_cycle", 32'(rise_pulse), 32'd0);
    repeat (3) @(negedge clk);

    // 3-cycle bounce on channel 1 is rejected
    raw_in = 3'b011;
    repeat (3) @(negedge clk);
    raw_in = 3'b001;
    repeat (10) @(negedge clk);
    chk("bounce_level", 32'(level_out), 32'b001);
    chk("bounce_glitch", 32'(glitch_cnt), 32'(gl_exp(1)));

    // Simultaneous fall on ch0 and rise on ch2
    raw_in = 3'b100;
    push(3'b100, 3'b001, 3'b100);
    repeat (LAT) @(negedge clk);
    chk("simul_level", 32'(level_out), 32'b100);
    repeat (3) @(negedge clk);

    raw_in = 3'b000;
    push(3'b000, 3'b100, 3'b000);
    repeat (LAT + 3) @(negedge clk);
    chk("drop_level", 32'(level_out), 32'd0);

    // Reset while ch2 count is at 2
    raw_in = 3'b100;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_level", 32'(level_out), 32'd0);
    chk("midreset_glitch", 32'(glitch_cnt), 32'd0);
    push(3'b100, 3'b000, 3'b100);
    repeat (LAT - 1) @(negedge clk);
    chk("postreset_not_early", 32'(level_out), 32'd0);
    @(negedge clk);
    chk("postreset_level", 32'(level_out), 32'b100);
    repeat (3) @(negedge clk);

    // 300 two-cycle glitches on ch0: counter saturates
    ng = 0;
    for (int i = 0; i < 300; i++) begin
      raw_in = 3'b101;
      repeat (2) @(negedge clk);
      raw_in = 3'b100;
      repeat (4) @(negedge clk);
      ng++;
      if (i == 99) chk("glitch_100", 32'(glitch_cnt), 32'(gl_exp(ng)));
      if (i == 254) chk("glitch_255", 32'(glitch_cnt), 32'(gl_exp(ng)));
    end
    chk("glitch_sat", 32'(glitch_cnt), 32'(gl_exp(ng)));
    chk("glitch_level", 32'(level_out), 32'b100);
    repeat (10) @(negedge clk);
    chk("glitch_hold", 32'(glitch_cnt), 32'(gl_exp(ng)));

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_input_conditioner.md
# fsm_input_conditioner

Input conditioning stage placed directly upstream of the access-control FSM pair (Moore credential tracker + Mealy actuator). It resynchronises the raw pad inputs (C1, C2, I) into `clk`, debounces each channel with a consecutive-stable-cycle counter, and produces clean debounced levels plus single-cycle rise/fall pulses that the FSMs consume in place of the raw pins. An optional saturating glitch counter reports how many bounces were rejected.

## Interface

Parameters:
- `N_CH`, 3: number of independent input channels (bit 0 = C1, bit 1 = C2, bit 2 = I in the top level).
- `SYNC_STAGES`, 2: synchroniser flop depth per channel; legal range 2..4.
- `DEBOUNCE_CYCLES`, 16: consecutive synchronised-stable cycles required to accept a new level; legal range ≥1. Counter width is `max(1, clog2(DEBOUNCE_CYCLES))`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `raw_in`  in  N_CH  asynchronous raw inputs from pads.
- `level_out`  out  N_CH  debounced level, registered.
- `rise_pulse`  out  N_CH  one-cycle pulse when `level_out[i]` goes 0→1, registered.
- `fall_pulse`  out  N_CH  one-cycle pulse when `level_out[i]` goes 1→0, registered.
- `glitch_cnt`  out  8  saturating count of rejected glitches; constant 0 when feature compiled out.

## Operation

- Per channel i: `SYNC_STAGES`-deep flop chain on `raw_in[i]`; last stage is `s[i]`.
- Per channel state: `stable[i]` (drives `level_out[i]`), counter `c[i]`.
- Each edge, per channel:
  - `s == stable`: `c <= 0`. If `c != 0` at that edge, a glitch is recorded (see Configuration).
  - `s != stable` and `c == DEBOUNCE_CYCLES-1`: `stable <= s`, `c <= 0`, and the matching `rise_pulse`/`fall_pulse` bit is set for the following cycle.
  - `s != stable` otherwise: `c <= c + 1`.
- Pulse registers are cleared every edge unless set by the rule above; a pulse is never longer than one cycle.
- Channels are fully independent; simultaneous changes on several channels produce simultaneous pulses in the same cycle.
- `DEBOUNCE_CYCLES = 1`: new level accepted on the first edge where `s != stable`.
- A bounce that returns to the stable value restarts the count from 0; the count never carries over.

## Timing

- Reset values: synchroniser flops 0, `stable` 0, `c` 0, `level_out` 0, `rise_pulse` 0, `fall_pulse` 0, `glitch_cnt` 0.
- Reset takes effect on the first rising edge where `reset` = 1 and overrides all other activity, including an in-progress debounce.
- Latency: a `raw_in` step that stays constant is reflected on `level_out` and the pulse output exactly `SYNC_STAGES + DEBOUNCE_CYCLES` edges after the first edge that samples it. The pulse is high in the same cycle `level_out` first shows the new value.
- A `raw_in` held high through reset produces a `rise_pulse` `SYNC_STAGES + DEBOUNCE_CYCLES` edges after reset deassertion. This is intended: downstream FSMs see a clean edge.
- Minimum accepted pulse width on `raw_in`: `DEBOUNCE_CYCLES` cycles. Shorter pulses are rejected.

## Configuration

- Macro `FSM_IN_GLITCH_CNT_EN`.
- Defined: 8-bit `glitch_cnt` increments by 1 on any edge where at least one channel records a glitch (`s == stable` while `c != 0`). Multiple channels glitching on the same edge count once. Saturates at 255. Cleared only by `reset`.
- Undefined: no counter logic is built, and `glitch_cnt` is tied to 8'h00. All other behaviour is identical.

## Test plan

All scenarios use `N_CH=3`, `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=4`.

- Reset 2 cycles, `raw_in`=3'b000 for 20 cycles -> all outputs 0 throughout, `glitch_cnt`=0.
- `raw_in[0]` 0→1 sampled at edge E and held -> `level_out[0]`=1 and `rise_pulse[0]`=1 after edge E+5 (6 edges). The pulse is high exactly 1 cycle. Other bits stay 0.
- `raw_in[1]` high for 3 cycles then low -> `level_out[1]` stays 0 and no pulses. `glitch_cnt`=1 with `FSM_IN_GLITCH_CNT_EN`, 0 without.
- With `level_out`=3'b001: `raw_in[0]` falls and `raw_in[2]` rises on the same edge -> `fall_pulse`=3'b001 and `rise_pulse`=3'b100 in the same cycle, then `level_out`=3'b100.
- `raw_in[2]` rises, `reset` pulsed 1 cycle while `c[2]`=2 -> outputs return to 0. With raw still high, `level_out[2]` rises 6 edges after reset deasserts.
- 300 separate 2-cycle glitches on `raw_in[0]` (macro defined) -> `glitch_cnt` reaches 255 and holds. `level_out[0]` stays 0.
